// File: rtl/wqe_sched_pkg.sv
// rtl/wqe_sched_pkg.sv - shared class and FSM state encodings for the WQE class scheduler
package wqe_sched_pkg;

    localparam logic CLS_LS = 1'b0;
    localparam logic CLS_BS = 1'b1;

    typedef enum logic {
        SERVE_LS = 1'b0,
        SERVE_BS = 1'b1
    } sched_state_t;

endpackage

// File: rtl/wqe_sched_credit.sv
// rtl/wqe_sched_credit.sv - single saturating credit counter with load and decrement
module wqe_sched_credit #(
    parameter int WIDTH = 4
) (
    input  logic             sys_clk,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cred
);

    logic [WIDTH-1:0] r_cred;
    logic [WIDTH-1:0] w_base;

    // A load and a decrement in the same cycle consume from the freshly loaded value.
    always_comb begin
        w_base = i_load ? i_load_val : r_cred;
    end

    always_ff @(posedge sys_clk) begin
        if (i_dec && (w_base != '0)) begin
            r_cred <= w_base - 1'b1;
        end else begin
            r_cred <= w_base;
        end
    end

    assign o_cred = r_cred;

endmodule

// File: rtl/wqe_class_sched.sv
// rtl/wqe_class_sched.sv - weighted round-robin LS/BS WQE scheduler with BS starvation guard
module wqe_class_sched
    import wqe_sched_pkg::*;
#(
    parameter int WQE_WIDTH    = 512,
    parameter int WEIGHT_WIDTH = 4,
    parameter int STARVE_WIDTH = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [WEIGHT_WIDTH-1:0] i_cfg_ls_weight,
    input  logic [WEIGHT_WIDTH-1:0] i_cfg_bs_weight,
    input  logic [STARVE_WIDTH-1:0] i_cfg_starve_limit,
    input  logic                    i_rd,
    input  logic                    i_ls_empty,
    input  logic                    i_bs_empty,
    output logic                    o_ls_ren,
    output logic                    o_bs_ren,
    input  logic [WQE_WIDTH-1:0]    i_ls_rdata,
    input  logic [WQE_WIDTH-1:0]    i_bs_rdata,
    output logic                    o_wqe_val,
    output logic [WQE_WIDTH-1:0]    o_wqe,
    output logic                    o_wqe_cls,
    output logic                    o_empty
);

    sched_state_t            r_state;
    sched_state_t            w_state_nxt;
    logic [STARVE_WIDTH-1:0] r_starve;
    logic                    r_wqe_val;
    logic                    r_wqe_cls;

    logic [WEIGHT_WIDTH-1:0] w_ls_cred;
    logic [WEIGHT_WIDTH-1:0] w_bs_cred;
    logic [WEIGHT_WIDTH-1:0] w_ls_wt;
    logic [WEIGHT_WIDTH-1:0] w_bs_wt;
    logic                    w_ls_ne;
    logic                    w_bs_ne;
    logic                    w_ls_ok;
    logic                    w_bs_ok;
    logic                    w_force;
    logic                    w_req;
    logic                    w_reload;
    logic                    w_gnt_ls;
    logic                    w_gnt_bs;

    assign w_ls_wt = (i_cfg_ls_weight == '0) ? WEIGHT_WIDTH'(1) : i_cfg_ls_weight;
    assign w_bs_wt = (i_cfg_bs_weight == '0) ? WEIGHT_WIDTH'(1) : i_cfg_bs_weight;

    assign w_ls_ne = ~i_ls_empty;
    assign w_bs_ne = ~i_bs_empty;
    assign w_ls_ok = w_ls_ne & (w_ls_cred != '0);
    assign w_bs_ok = w_bs_ne & (w_bs_cred != '0);
    assign w_force = (i_cfg_starve_limit != '0) && (r_starve >= i_cfg_starve_limit) && w_bs_ne;
    assign w_req   = i_rd & ~sys_rst & (w_ls_ne | w_bs_ne);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_ls    = 1'b0;
        w_gnt_bs    = 1'b0;
        w_reload    = 1'b0;
        if (w_req) begin
            if (w_force) begin
                w_gnt_bs = 1'b1;
            end else if ((r_state == SERVE_LS) && w_ls_ok) begin
                w_gnt_ls = 1'b1;
            end else if ((r_state == SERVE_BS) && w_bs_ok) begin
                w_gnt_bs = 1'b1;
            end else if ((r_state == SERVE_LS) && w_bs_ok) begin
                w_gnt_bs    = 1'b1;
                w_state_nxt = SERVE_BS;
            end else if ((r_state == SERVE_BS) && w_ls_ok) begin
                w_gnt_ls    = 1'b1;
                w_state_nxt = SERVE_LS;
            end else begin
                // Round over: reloaded weights are always >= 1, so a non-empty class wins now.
                w_reload    = 1'b1;
                w_state_nxt = SERVE_LS;
                w_gnt_ls    = w_ls_ne;
                w_gnt_bs    = ~w_ls_ne;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= SERVE_LS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    wqe_sched_credit #(.WIDTH(WEIGHT_WIDTH)) u_ls_credit (
        .sys_clk    (sys_clk),
        .i_load     (sys_rst | w_reload),
        .i_load_val (w_ls_wt),
        .i_dec      (w_gnt_ls),
        .o_cred     (w_ls_cred)
    );

    wqe_sched_credit #(.WIDTH(WEIGHT_WIDTH)) u_bs_credit (
        .sys_clk    (sys_clk),
        .i_load     (sys_rst | w_reload),
        .i_load_val (w_bs_wt),
        .i_dec      (w_gnt_bs),
        .o_cred     (w_bs_cred)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !w_bs_ne || w_gnt_bs) begin
            r_starve <= '0;
        end else if (i_rd && (r_starve != '1)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wqe_val <= 1'b0;
            r_wqe_cls <= CLS_LS;
        end else begin
            r_wqe_val <= w_gnt_ls | w_gnt_bs;
            if (w_gnt_ls || w_gnt_bs) begin
                r_wqe_cls <= w_gnt_bs ? CLS_BS : CLS_LS;
            end
        end
    end

    assign o_ls_ren  = w_gnt_ls;
    assign o_bs_ren  = w_gnt_bs;
    // Masking with reset drops the data of a grant issued just before reset.
    assign o_wqe_val = r_wqe_val & ~sys_rst;
    assign o_wqe_cls = r_wqe_cls;
    assign o_wqe     = (r_wqe_cls == CLS_BS) ? i_bs_rdata : i_ls_rdata;
    assign o_empty   = i_ls_empty & i_bs_empty;

endmodule

// File: tb/tb_wqe_class_sched.sv
// tb/tb_wqe_class_sched.sv - self-checking bench for wqe_class_sched against a queue-based model
module tb_wqe_class_sched;

    localparam int W = 64;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic [3:0]   i_cfg_ls_weight = 4'd3;
    logic [3:0]   i_cfg_bs_weight = 4'd1;
    logic [7:0]   i_cfg_starve_limit = 8'd0;
    logic         i_rd = 1'b0;
    logic         i_ls_empty = 1'b1;
    logic         i_bs_empty = 1'b1;
    logic         o_ls_ren, o_bs_ren;
    logic [W-1:0] i_ls_rdata = '0;
    logic [W-1:0] i_bs_rdata = '0;
    logic         o_wqe_val;
    logic [W-1:0] o_wqe;
    logic         o_wqe_cls;
    logic         o_empty;

    wqe_class_sched #(.WQE_WIDTH(W), .WEIGHT_WIDTH(4), .STARVE_WIDTH(8)) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .i_cfg_ls_weight    (i_cfg_ls_weight),
        .i_cfg_bs_weight    (i_cfg_bs_weight),
        .i_cfg_starve_limit (i_cfg_starve_limit),
        .i_rd               (i_rd),
        .i_ls_empty         (i_ls_empty),
        .i_bs_empty         (i_bs_empty),
        .o_ls_ren           (o_ls_ren),
        .o_bs_ren           (o_bs_ren),
        .i_ls_rdata         (i_ls_rdata),
        .i_bs_rdata         (i_bs_rdata),
        .o_wqe_val          (o_wqe_val),
        .o_wqe              (o_wqe),
        .o_wqe_cls          (o_wqe_cls),
        .o_empty            (o_empty)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ls_q[$];
    logic [W-1:0] bs_q[$];
    int ls_seq = 0;
    int bs_seq = 0;

    // Reference model: class credits, which class the round is serving, BS wait count, pending output.
    int           m_ls_c, m_bs_c, m_starve;
    bit           m_serve_bs;
    bit           m_pv, m_pc;
    logic [W-1:0] m_pd;

    logic [1:0]   exp_ren, act_ren;
    bit           exp_val, act_val, exp_cls, act_cls, exp_empty, act_empty;
    logic [W-1:0] exp_wqe, act_wqe;

    function automatic int wmap(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic push(input bit cls, input int n);
        for (int k = 0; k < n; k++) begin
            if (cls) begin
                bs_q.push_back(64'h2000_0000_0000_0000 + 64'(bs_seq));
                bs_seq++;
            end else begin
                ls_q.push_back(64'h1000_0000_0000_0000 + 64'(ls_seq));
                ls_seq++;
            end
        end
    endtask

    task automatic model_reset();
        m_ls_c     = wmap(int'(i_cfg_ls_weight));
        m_bs_c     = wmap(int'(i_cfg_bs_weight));
        m_serve_bs = 1'b0;
        m_starve   = 0;
        m_pv       = 1'b0;
        m_pc       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        i_rd    = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: entered just after a negedge, returns just after the next negedge.
    task automatic step(input bit rd);
        bit ls_ne, bs_ne, force_bs, cur_ok, oth_ok;
        int g, lim;
        logic [W-1:0] popped;
        i_rd       = rd;
        i_ls_empty = (ls_q.size() == 0);
        i_bs_empty = (bs_q.size() == 0);
        ls_ne      = !i_ls_empty;
        bs_ne      = !i_bs_empty;
        #1;
        act_ren   = {o_ls_ren, o_bs_ren};
        act_val   = o_wqe_val;
        act_cls   = o_wqe_cls;
        act_wqe   = o_wqe;
        act_empty = o_empty;
        exp_val   = m_pv;
        exp_cls   = m_pc;
        exp_wqe   = m_pd;
        exp_empty = !ls_ne && !bs_ne;
        g   = 0;
        lim = int'(i_cfg_starve_limit);
        if (rd && (ls_ne || bs_ne)) begin
            force_bs = (lim != 0) && (m_starve >= lim) && bs_ne;
            cur_ok   = m_serve_bs ? (bs_ne && m_bs_c > 0) : (ls_ne && m_ls_c > 0);
            oth_ok   = m_serve_bs ? (ls_ne && m_ls_c > 0) : (bs_ne && m_bs_c > 0);
            if (force_bs) begin
                g = 2;
            end else if (cur_ok) begin
                g = m_serve_bs ? 2 : 1;
            end else if (oth_ok) begin
                g = m_serve_bs ? 1 : 2;
                m_serve_bs = !m_serve_bs;
            end else begin
                m_ls_c     = wmap(int'(i_cfg_ls_weight));
                m_bs_c     = wmap(int'(i_cfg_bs_weight));
                m_serve_bs = 1'b0;
                g = ls_ne ? 1 : 2;
            end
        end
        exp_ren = {g == 1, g == 2};
        popped  = '0;
        if (g == 1) begin
            m_ls_c = (m_ls_c > 0) ? m_ls_c - 1 : 0;
            popped = ls_q.pop_front();
        end else if (g == 2) begin
            m_bs_c = (m_bs_c > 0) ? m_bs_c - 1 : 0;
            popped = bs_q.pop_front();
        end
        if (!bs_ne || g == 2) m_starve = 0;
        else if (rd) m_starve = (m_starve < 255) ? m_starve + 1 : 255;
        m_pv = (g != 0);
        if (g != 0) begin
            m_pc = (g == 2);
            m_pd = popped;
        end
        @(negedge sys_clk);
        if (g == 1) i_ls_rdata = popped;
        if (g == 2) i_bs_rdata = popped;
    endtask

    task automatic test_reset();
        i_cfg_ls_weight = 4'd3;
        i_cfg_bs_weight = 4'd1;
        i_ls_empty = 1'b0;
        i_bs_empty = 1'b0;
        i_rd = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        #1;
        checks++;
        if ({o_ls_ren, o_bs_ren} !== 2'b00) begin
            errors++; $display("FAIL reset_ren got=%b exp=00", {o_ls_ren, o_bs_ren});
        end
        checks++;
        if ({o_wqe_val, o_wqe_cls} !== 2'b00) begin
            errors++; $display("FAIL reset_val_cls got=%b exp=00", {o_wqe_val, o_wqe_cls});
        end
        checks++;
        if (o_empty !== 1'b0) begin
            errors++; $display("FAIL reset_empty_lo got=%b exp=0", o_empty);
        end
        i_ls_empty = 1'b1;
        i_bs_empty = 1'b1;
        #1;
        checks++;
        if (o_empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty_hi got=%b exp=1", o_empty);
        end
        do_reset();
    endtask

    task automatic test_wrr_3_1();
        i_cfg_ls_weight = 4'd3; i_cfg_bs_weight = 4'd1; i_cfg_starve_limit = 8'd0;
        ls_q.delete(); bs_q.delete();
        push(0, 30); push(1, 30);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(i < 16);
            checks++;
            if (act_ren !== exp_ren) begin
                errors++; $display("FAIL wrr_ren cyc=%0d got=%b exp=%b", i, act_ren, exp_ren);
            end
            if (i < 16) begin
                checks++;
                if (act_ren !== ((i % 4 == 3) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL wrr_pattern cyc=%0d got=%b", i, act_ren);
                end
            end
            checks++;
            if (act_val !== exp_val) begin
                errors++; $display("FAIL wrr_val cyc=%0d got=%b exp=%b", i, act_val, exp_val);
            end
            if (exp_val) begin
                checks++;
                if (act_cls !== exp_cls || act_wqe !== exp_wqe) begin
                    errors++; $display("FAIL wrr_cls cyc=%0d got=%b/%h exp=%b/%h", i, act_cls, act_wqe, exp_cls, exp_wqe);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int run, maxrun;
        i_cfg_ls_weight = 4'd15; i_cfg_bs_weight = 4'd1; i_cfg_starve_limit = 8'd4;
        ls_q.delete(); bs_q.delete();
        push(0, 60); push(1, 60);
        do_reset();
        run = 0; maxrun = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            checks++;
            if (act_ren !== exp_ren) begin
                errors++; $display("FAIL starve_ren cyc=%0d got=%b exp=%b", i, act_ren, exp_ren);
            end
            run = (act_ren === 2'b10) ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        checks++;
        if (maxrun > 4 || maxrun == 0) begin
            errors++; $display("FAIL starve_run got=%0d exp=1..4", maxrun);
        end
    endtask

    task automatic test_work_conserving();
        i_cfg_ls_weight = 4'd2; i_cfg_bs_weight = 4'd1; i_cfg_starve_limit = 8'd0;
        ls_q.delete(); bs_q.delete();
        push(1, 5);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++;
            if (act_ren !== ((i < 5) ? 2'b01 : 2'b00) || act_ren !== exp_ren) begin
                errors++; $display("FAIL wc_ren cyc=%0d got=%b exp=%b", i, act_ren, exp_ren);
            end
            checks++;
            if (act_val !== exp_val) begin
                errors++; $display("FAIL wc_val cyc=%0d got=%b exp=%b", i, act_val, exp_val);
            end
        end
        checks++;
        if (act_empty !== 1'b1) begin
            errors++; $display("FAIL wc_empty got=%b exp=1", act_empty);
        end
    endtask

    task automatic test_cfg_midround();
        logic [1:0] pat [7];
        pat = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        i_cfg_ls_weight = 4'd2; i_cfg_bs_weight = 4'd1; i_cfg_starve_limit = 8'd0;
        ls_q.delete(); bs_q.delete();
        push(0, 20); push(1, 20);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (i == 0) i_cfg_ls_weight = 4'd1;
            checks++;
            if (act_ren !== pat[i] || act_ren !== exp_ren) begin
                errors++; $display("FAIL cfg_ren cyc=%0d got=%b exp=%b", i, act_ren, pat[i]);
            end
        end
    endtask

    task automatic test_reset_drop();
        logic [1:0] pat [3];
        pat = '{2'b10, 2'b10, 2'b01};
        i_cfg_ls_weight = 4'd2; i_cfg_bs_weight = 4'd1; i_cfg_starve_limit = 8'd0;
        ls_q.delete(); bs_q.delete();
        push(0, 10); push(1, 10);
        do_reset();
        step(1);
        checks++;
        if (act_ren !== 2'b10) begin
            errors++; $display("FAIL rstdrop_first got=%b exp=10", act_ren);
        end
        sys_rst = 1'b1;
        i_rd = 1'b1;
        #1;
        checks++;
        if ({o_ls_ren, o_bs_ren, o_wqe_val} !== 3'b000) begin
            errors++; $display("FAIL rstdrop_during got=%b exp=000", {o_ls_ren, o_bs_ren, o_wqe_val});
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (i == 0) begin
                checks++;
                if (act_val !== 1'b0) begin
                    errors++; $display("FAIL rstdrop_val got=%b exp=0", act_val);
                end
            end
            checks++;
            if (act_ren !== pat[i] || act_ren !== exp_ren) begin
                errors++; $display("FAIL rstdrop_ren cyc=%0d got=%b exp=%b", i, act_ren, pat[i]);
            end
        end
    endtask

    task automatic test_zero_weights();
        i_cfg_ls_weight = 4'd0; i_cfg_bs_weight = 4'd0; i_cfg_starve_limit = 8'd0;
        ls_q.delete(); bs_q.delete();
        push(0, 20); push(1, 20);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++;
            if (act_ren !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL zero_ren cyc=%0d got=%b", i, act_ren);
            end
        end
    endtask

    task automatic test_random();
        i_cfg_ls_weight    = 4'($urandom_range(0, 15));
        i_cfg_bs_weight    = 4'($urandom_range(0, 15));
        i_cfg_starve_limit = 8'($urandom_range(0, 6));
        ls_q.delete(); bs_q.delete();
        push(0, 4); push(1, 4);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) begin
                i_cfg_ls_weight    = 4'($urandom_range(0, 15));
                i_cfg_bs_weight    = 4'($urandom_range(0, 15));
                i_cfg_starve_limit = 8'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 3) == 0) push(0, $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) push(1, $urandom_range(1, 3));
            step($urandom_range(0, 3) != 0);
            checks++;
            if (act_ren !== exp_ren) begin
                errors++; $display("FAIL rand_ren cyc=%0d got=%b exp=%b", i, act_ren, exp_ren);
            end
            checks++;
            if (act_val !== exp_val || act_empty !== exp_empty) begin
                errors++; $display("FAIL rand_val_empty cyc=%0d got=%b%b exp=%b%b", i, act_val, act_empty, exp_val, exp_empty);
            end
            if (exp_val) begin
                checks++;
                if (act_cls !== exp_cls || act_wqe !== exp_wqe) begin
                    errors++; $display("FAIL rand_wqe cyc=%0d got=%b/%h exp=%b/%h", i, act_cls, act_wqe, exp_cls, exp_wqe);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrr_3_1();
        test_starvation();
        test_work_conserving();
        test_cfg_midround();
        test_reset_drop();
        test_zero_weights();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wqe_class_sched.md
WQE_CLASS_SCHED -- requirements
Module: wqe_class_sched

Interface
REQ-001 SHALL have parameter WQE_WIDTH, default 512, WQE width in bits.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 4, per-class weight/credit width.
REQ-003 SHALL have parameter STARVE_WIDTH, default 8, starvation counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with these ports:
- sys_clk  in  1  the single clock.
- sys_rst  in  1  synchronous active-high reset.
- i_cfg_ls_weight  in  WEIGHT_WIDTH  latency-sensitive (LS) grants per round.
- i_cfg_bs_weight  in  WEIGHT_WIDTH  bandwidth-sensitive (BS) grants per round.
- i_cfg_starve_limit  in  STARVE_WIDTH  BS starvation limit; 0 disables the guard.
- i_rd  in  1  consumer pops one WQE this cycle.
- i_ls_empty, i_bs_empty  in  1 each  per-class FIFO empty flags.
- o_ls_ren, o_bs_ren  out  1 each  FIFO read enables; FIFO read latency is 1 cycle.
- i_ls_rdata, i_bs_rdata  in  WQE_WIDTH each  FIFO read data.
- o_wqe_val  out  1  o_wqe valid.
- o_wqe  out  WQE_WIDTH  selected WQE.
- o_wqe_cls  out  1  class of o_wqe: 0 = LS, 1 = BS.
- o_empty  out  1  i_ls_empty & i_bs_empty, combinational.

Function
REQ-005 SHALL hold two credit counters, ls_cred and bs_cred, plus a 2-state FSM: SERVE_LS, SERVE_BS.
REQ-006 SHALL grant at most one class per cycle, and only when i_rd=1 and that class's FIFO is non-empty; o_ls_ren and o_bs_ren SHALL never both be 1.
REQ-007 SHALL evaluate the grant in this priority order:
- (a) Starvation force: BS is granted.
- (b) Current state's class, if non-empty with credit > 0.
- (c) The other class, if non-empty with credit > 0; the FSM switches to that class.
- (d) Otherwise the round ends (see REQ-009).
REQ-008 SHALL decrement the granted class's credit by 1, saturating at 0, including grants made under (a).
REQ-009 SHALL end a round when neither non-empty class has credit:
- ls_cred and bs_cred reload from the cfg weights in that same cycle.
- The FSM goes to SERVE_LS.
- The grant in that cycle uses the reloaded credits, so LS is granted if non-empty.
REQ-010 SHALL treat a weight of 0 as 1.
REQ-011 SHALL sample the cfg weights only at reload and reset; mid-round cfg changes take effect at the next round.
REQ-012 SHALL keep the starvation counter starve_cnt:
- Increments, saturating, each cycle with i_rd=1, BS non-empty and no BS grant.
- Clears on a BS grant, or whenever BS is empty.
REQ-013 SHALL assert starvation force when i_cfg_starve_limit != 0, starve_cnt >= i_cfg_starve_limit and BS is non-empty.
REQ-014 SHALL drive read enables combinationally: o_ls_ren/o_bs_ren = i_rd & grant.
REQ-015 SHALL assert o_wqe_val exactly 1 cycle after any ren, with o_wqe_cls registered from that grant.
REQ-016 SHALL drive o_wqe combinationally as i_bs_rdata when o_wqe_cls=1, else i_ls_rdata.
REQ-017 SHALL, when i_rd=1 and both FIFOs are empty, issue no ren, leave credits and FSM unchanged, and hold starve_cnt at 0.
REQ-018 SHALL ignore i_rd while o_empty=1; no error output is generated.

Reset
REQ-019 SHALL, on sys_rst=1 at a sys_clk edge, set:
- FSM = SERVE_LS.
- ls_cred and bs_cred = the cfg weights (0 mapped to 1).
- starve_cnt = 0.
- o_wqe_val = 0, o_wqe_cls = 0.
REQ-020 SHALL force o_ls_ren = o_bs_ren = 0 combinationally while sys_rst=1.
REQ-021 SHALL drop a grant issued in the cycle before reset: no o_wqe_val follows it.

Structure
REQ-022 SHALL place the class encodings (CLS_LS=0, CLS_BS=1) and the FSM state encodings in the shared package wqe_sched_pkg.
REQ-023 SHALL use one sub-module, wqe_sched_credit: a single saturating credit counter with load/decrement, instantiated once per class.

Verification
REQ-024 Weights LS=3, BS=1, limit 0, both FIFOs full, i_rd held high -> ren pattern LS,LS,LS,BS repeating; o_wqe_val follows each ren by 1 cycle with a matching o_wqe_cls.
REQ-025 Weights LS=15, BS=1, limit 4, both FIFOs full, i_rd high -> no more than 4 consecutive LS grants occur while BS is non-empty.
REQ-026 LS empty, BS holding 5 entries, weights 2/1, i_rd high -> 5 BS grants in consecutive cycles (work-conserving), then no ren; o_empty=1.
REQ-027 Change weight LS from 2 to 1 mid-round -> the current round still gives 2 LS grants; the next round gives 1.
REQ-028 Assert sys_rst on the cycle after an LS ren -> o_wqe_val=0 the next cycle; after release the first grant is LS with full credits.
REQ-029 Weight LS=0, BS=0, both FIFOs full -> strict LS,BS alternation.
